llc_set_admit: RTL and testbench

In-flight set admission controller for the LLC request path. It sits between the request input FIFO and the LLC processing pipeline. It holds one incoming request and compares its set against a table of up to TABLE_SIZE in-flight sets. A request is issued, tagged with a table slot, only when its set is not already in flight and a slot is free. Completion packets from the pipeline free slots by pointer.

---
 rtl/llc_set_admit.sv | 149 ++++++++++++++
 tb/tb_llc_set_admit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_set_admit.sv
`timescale 1ns/1ps
// llc_set_admit
// In-flight set admission controller for the LLC request path. One request is
// held at a time and released to the pipeline only when its set is not
// already in flight and a table slot is free. The pipeline returns slots by
// pointer on done_valid.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   req_valid/ready request handshake, req_set is the incoming set index
//   issue_valid/rdy admitted request handshake; issue_set/issue_ptr stable
//                   while issue_valid is high and issue_ready is low
//   done_valid/ptr  frees the slot done_ptr
//   occupancy/full  registered count of valid slots, full at TABLE_SIZE
//   conflict_stall  held request blocked by a matching in-flight set
//   err_bad_done    sticky: a done hit an invalid or out-of-range slot

`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif

module llc_set_admit #(
    parameter int SET_BITS   = `LLC_SET_BITS,
    parameter int TABLE_SIZE = 5,
    parameter int PTR_BITS   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SET_BITS-1:0] req_set,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [SET_BITS-1:0] issue_set,
    output logic [PTR_BITS-1:0] issue_ptr,
    input  logic                done_valid,
    input  logic [PTR_BITS-1:0] done_ptr,
    output logic [PTR_BITS-1:0] occupancy,
    output logic                full,
    output logic                conflict_stall,
    output logic                err_bad_done
);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

    state_t                state;
    logic [TABLE_SIZE-1:0] slot_valid;
    logic [SET_BITS-1:0]   slot_set [TABLE_SIZE];
    logic [SET_BITS-1:0]   hold_set;

    logic                  match;
    logic                  free_found;
    logic [PTR_BITS-1:0]   free_idx;
    logic                  done_hit;
    logic                  alloc;
    logic                  freeing;

    // All lookups use the registered valid bits, so a slot freed at an edge
    // only becomes allocatable (and stops matching) from that edge onward.
    always_comb begin
        match      = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        done_hit   = 1'b0;
        for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
            if (slot_valid[i] && (slot_set[i] == hold_set)) begin
                match = 1'b1;
            end
            if (!slot_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = PTR_BITS'(i);
            end
            if (slot_valid[i] && (done_ptr == PTR_BITS'(i))) begin
                done_hit = 1'b1;
            end
        end
    end

    assign alloc          = (state == CHECK) && !match && free_found;
    assign freeing        = done_valid && done_hit;
    assign conflict_stall = (state == CHECK) && match;
    assign full           = (occupancy == PTR_BITS'(TABLE_SIZE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            slot_valid   <= '0;
            hold_set     <= '0;
            req_ready    <= 1'b1;
            issue_valid  <= 1'b0;
            issue_set    <= '0;
            issue_ptr    <= '0;
            occupancy    <= '0;
            err_bad_done <= 1'b0;
            for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
                slot_set[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        hold_set  <= req_set;
                        req_ready <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (alloc) begin
                        issue_set   <= hold_set;
                        issue_ptr   <= free_idx;
                        issue_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A freed slot is valid and the allocated one is free, so the two
            // never collide and both writes can land in the same edge.
            for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
                if (freeing && (done_ptr == PTR_BITS'(i))) begin
                    slot_valid[i] <= 1'b0;
                end
                if (alloc && (free_idx == PTR_BITS'(i))) begin
                    slot_valid[i] <= 1'b1;
                    slot_set[i]   <= hold_set;
                end
            end

            case ({alloc, freeing})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            if (done_valid && !done_hit) begin
                err_bad_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_llc_set_admit.sv
`timescale 1ns/1ps
module tb_llc_set_admit;

    localparam int TS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_set = '0;
    logic       issue_valid;
    logic       issue_ready = 1'b0;
    logic [7:0] issue_set;
    logic [2:0] issue_ptr;
    logic       done_valid = 1'b0;
    logic [2:0] done_ptr = '0;
    logic [2:0] occupancy;
    logic       full;
    logic       conflict_stall;
    logic       err_bad_done;

    llc_set_admit #(.SET_BITS(8), .TABLE_SIZE(TS), .PTR_BITS(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_set(issue_set), .issue_ptr(issue_ptr),
        .done_valid(done_valid), .done_ptr(done_ptr),
        .occupancy(occupancy), .full(full),
        .conflict_stall(conflict_stall), .err_bad_done(err_bad_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction phases (0 waiting for a request, 1 holding,
    // 2 presenting), a table of in-flight sets, and a queue of expected issues.
    typedef struct packed { bit [7:0] set; bit [2:0] ptr; } exp_t;
    exp_t     exp_q[$];
    int       m_phase;
    bit [7:0] m_set;
    bit       m_valid [8];
    bit [7:0] m_sets  [8];
    bit       m_err;
    bit       m_nv    [8];
    bit       m_free;
    int       m_slot;

    function automatic int count_valid();
        int c = 0;
        for (int i = 0; i < TS; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic bit in_flight(input bit [7:0] s);
        for (int i = 0; i < TS; i++) if (m_valid[i] && m_sets[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < TS; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_set   = '0;
            m_err   = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 1'b0;
                m_sets[i]  = '0;
            end
        end else begin
            m_free = done_valid && (int'(done_ptr) < TS) && m_valid[done_ptr];
            if (done_valid && !m_free) m_err = 1'b1;
            for (int i = 0; i < 8; i++) m_nv[i] = m_valid[i];
            if (m_free) m_nv[done_ptr] = 1'b0;
            case (m_phase)
                0: if (req_valid) begin
                    m_set   = req_set;
                    m_phase = 1;
                end
                1: if (!in_flight(m_set) && count_valid() < TS) begin
                    m_slot = lowest_free();
                    m_nv[m_slot]   = 1'b1;
                    m_sets[m_slot] = m_set;
                    exp_q.push_back('{set: m_set, ptr: 3'(m_slot)});
                    m_phase = 2;
                end
                default: if (issue_ready) m_phase = 0;
            endcase
            for (int i = 0; i < 8; i++) m_valid[i] = m_nv[i];
        end
    end

    // Monitor: compares every cycle, mid-period, and retires expected issues
    // on the handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("req_ready", int'(req_ready), int'(m_phase == 0));
            chk("issue_valid", int'(issue_valid), int'(m_phase == 2));
            chk("occupancy", int'(occupancy), count_valid());
            chk("full", int'(full), int'(count_valid() == TS));
            chk("conflict_stall", int'(conflict_stall), int'(m_phase == 1 && in_flight(m_set)));
            chk("err_bad_done", int'(err_bad_done), int'(m_err));
            if (issue_valid) begin
                if (exp_q.size() == 0) begin
                    chk("issue_expected", exp_q.size(), 1);
                end else begin
                    chk("issue_set", int'(issue_set), int'(exp_q[0].set));
                    chk("issue_ptr", int'(issue_ptr), int'(exp_q[0].ptr));
                    if (issue_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s);
        req_valid = 1'b1;
        req_set   = s;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (m_phase != 0) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        chk("send_timeout", m_phase, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (m_phase == 0) return;
            tick();
        end
        chk("idle_timeout", m_phase, 0);
    endtask

    task automatic do_done(input logic [2:0] p);
        done_valid = 1'b1;
        done_ptr   = p;
        tick();
        done_valid = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < TS; i++) if (m_valid[i]) do_done(3'(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_issue_valid"}, int'(issue_valid), 0);
        chk({tag, "_issue_set"}, int'(issue_set), 0);
        chk({tag, "_issue_ptr"}, int'(issue_ptr), 0);
        chk({tag, "_occupancy"}, int'(occupancy), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_conflict"}, int'(conflict_stall), 0);
        chk({tag, "_err"}, int'(err_bad_done), 0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b1;
        mon_en = 1'b1;
        issue_ready = 1'b1;
        tick();

        // Single request: lands in slot 0.
        send(8'h1A);
        wait_idle();
        chk("first_occ", int'(occupancy), 1);
        clear_all();

        // Fill the table, then a sixth request waits on full.
        for (int i = 1; i <= 5; i++) begin
            send(8'(i));
            wait_idle();
        end
        chk("fill_full", int'(full), 1);
        send(8'h06);
        repeat (5) tick();
        chk("full_hold_no_conflict", int'(conflict_stall), 0);
        do_done(3'd2);
        wait_idle();
        clear_all();

        // Set conflict resolved by freeing the matching slot.
        send(8'h10);
        wait_idle();
        send(8'h10);
        repeat (4) tick();
        chk("conflict_seen", int'(conflict_stall), 1);
        do_done(3'd0);
        wait_idle();
        clear_all();

        // Back-pressure on the issue side.
        issue_ready = 1'b0;
        send(8'h22);
        repeat (6) tick();
        issue_ready = 1'b1;
        wait_idle();

        // Bad dones: an invalid slot and an out-of-range pointer.
        do_done(3'd3);
        chk("bad_done_sticky", int'(err_bad_done), 1);
        do_done(3'd6);
        tick();
        chk("bad_done_still", int'(err_bad_done), 1);
        clear_all();

        // Allocation and free in the same edge.
        send(8'h30);
        wait_idle();
        send(8'h31);
        do_done(3'd0);
        chk("occ_alloc_free", int'(occupancy), 1);
        wait_idle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            req_valid   = ($urandom_range(0, 1) == 1);
            req_set     = 8'($urandom_range(0, 7));
            issue_ready = ($urandom_range(0, 3) != 0);
            done_valid  = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                done_ptr = 3'($urandom_range(0, TS - 1));
                if (m_valid[done_ptr]) done_valid = 1'b1;
                else if ($urandom_range(0, 19) == 0) begin
                    done_ptr   = 3'($urandom_range(0, 7));
                    done_valid = 1'b1;
                end
            end
            tick();
        end
        req_valid  = 1'b0;
        done_valid = 1'b0;
        issue_ready = 1'b1;
        wait_idle();

        // Reset asserted while presenting an issue.
        issue_ready = 1'b0;
        send(8'h44);
        tick();
        chk("pre_reset_issue", int'(issue_valid), 1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        tick();
        tick();
        rst = 1'b1;
        issue_ready = 1'b1;
        repeat (3) tick();
        send(8'h45);
        wait_idle();
        tick();

        mon_en = 1'b0;
        chk("leftover_issues", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
